// File: rtl/counter.sv
// Prescaled up/down timebase counter feeding register readback and the PWM stage.
// Optional one-shot mode (oneshot/done ports) is built when COUNTER_ONESHOT_EN is defined.
module counter #(
  parameter int WIDTH     = 16,
  parameter int PSC_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 count_reset,
  input  logic                 upnotdown,
  input  logic [WIDTH-1:0]     period,
  input  logic [PSC_WIDTH-1:0] prescale,
`ifdef COUNTER_ONESHOT_EN
  input  logic                 oneshot,
  output logic                 done,
`endif
  output logic [WIDTH-1:0]     counter_val,
  output logic                 cnt_tick,
  output logic                 ovf
);

  logic [WIDTH-1:0]     counter_val_q, counter_val_d;
  logic [PSC_WIDTH-1:0] presc_cnt_q, presc_cnt_d;
  logic                 cnt_tick_q, cnt_tick_d;
  logic                 ovf_q, ovf_d;
  logic                 run;

`ifdef COUNTER_ONESHOT_EN
  logic done_q, done_d;
  assign run  = en && !done_q;
  assign done = done_q;
`else
  assign run = en;
`endif

  always_comb begin
    counter_val_d = counter_val_q;
    presc_cnt_d   = presc_cnt_q;
    cnt_tick_d    = 1'b0;
    ovf_d         = 1'b0;
`ifdef COUNTER_ONESHOT_EN
    done_d        = done_q;
`endif
    if (count_reset) begin
      counter_val_d = '0;
      presc_cnt_d   = '0;
`ifdef COUNTER_ONESHOT_EN
      done_d        = 1'b0;
`endif
    end else if (run) begin
      // ">=" so a prescale lowered below the current phase steps at once
      if (presc_cnt_q >= prescale) begin
        presc_cnt_d = '0;
        cnt_tick_d  = 1'b1;
        if (upnotdown) begin
          if (counter_val_q >= period) begin
            counter_val_d = '0;
            ovf_d         = 1'b1;
          end else begin
            counter_val_d = counter_val_q + WIDTH'(1);
          end
        end else begin
          if (counter_val_q == '0) begin
            counter_val_d = period;
            ovf_d         = 1'b1;
          end else begin
            counter_val_d = counter_val_q - WIDTH'(1);
          end
        end
`ifdef COUNTER_ONESHOT_EN
        if (ovf_d && oneshot) begin
          done_d = 1'b1;
        end
`endif
      end else begin
        presc_cnt_d = presc_cnt_q + PSC_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter_val_q <= '0;
      presc_cnt_q   <= '0;
      cnt_tick_q    <= 1'b0;
      ovf_q         <= 1'b0;
`ifdef COUNTER_ONESHOT_EN
      done_q        <= 1'b0;
`endif
    end else begin
      counter_val_q <= counter_val_d;
      presc_cnt_q   <= presc_cnt_d;
      cnt_tick_q    <= cnt_tick_d;
      ovf_q         <= ovf_d;
`ifdef COUNTER_ONESHOT_EN
      done_q        <= done_d;
`endif
    end
  end

  assign counter_val = counter_val_q;
  assign cnt_tick    = cnt_tick_q;
  assign ovf         = ovf_q;

endmodule
